pgate_bus_arbiter: RTL

//   Shares one bus segment among NREQ requesters, each joined to it by a
//   PGX4-style pass gate (drives when INN=1, INP=0).

---
 rtl/pgate_arb_pkg.sv | 50 +++++
 rtl/pgate_dead_timer.sv | 29 ++
 rtl/pgate_bus_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pgate_arb_pkg.sv
// Shared types and helpers for the pass-gate bus arbiter: FSM state encoding,
// round-robin pick function and elaboration-time parameter range checks.
package pgate_arb_pkg;

  localparam int MAX_NREQ = 16;
  localparam int MAX_DEAD = 15;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ON     = 2'd2,
    OFF    = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } pick_t;

  // First set request bit scanning upward from 'start', wrapping at nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [IDX_W-1:0]    start,
                                    input int                  nreq);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(start) + k) % nreq;
      if ((k < nreq) && !res.found && req[idx[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.index = idx[IDX_W-1:0];
      end
    end
    return res;
  endfunction

  // Legal parameter envelope of the arbiter.
  function automatic bit params_ok(input int nreq, input int dead, input int hold);
    return (nreq >= 2) && (nreq <= MAX_NREQ) &&
           (dead >= 0) && (dead <= MAX_DEAD) &&
           (hold >= 1);
  endfunction

  // The release phase always lasts at least one all-off cycle.
  function automatic int off_cycles(input int dead);
    return (dead > 0) ? dead : 1;
  endfunction

endpackage

// File: rtl/pgate_dead_timer.sv
// Dead-time down-counter shared by the SETTLE and OFF phases. After a load of
// N (N >= 1) the done flag is high during the N-th cycle, so the phase that
// loaded it lasts exactly N cycles.
module pgate_dead_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/pgate_bus_arbiter.sv
// Round-robin arbiter sharing one bus segment among NREQ pass gates.
// Enforces break-before-make dead time and a per-grant hold timeout. All gate
// enables and status outputs come straight from flops, one cycle behind the
// FSM state, so there is no combinational path from req to the gate drives.
module pgate_bus_arbiter
  import pgate_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         en_n,
  output logic [NREQ-1:0]         en_p,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    timeout
);

  localparam int OW      = $clog2(NREQ);
  localparam int HW      = $clog2(MAX_HOLD + 1);
  localparam int TW      = 4;
  localparam int OFF_CYC = off_cycles(DEAD_CYC);

  if (!params_ok(NREQ, DEAD_CYC, MAX_HOLD)) begin : g_bad_params
    $error("pgate_bus_arbiter: parameter out of range");
  end

  state_t state;
  state_t next_state;

  logic [MAX_NREQ-1:0] req_ext;
  pick_t               pick;
  logic [OW-1:0]       pick_idx;

  // winner: requester being settled/owning the bus.
  // rr_base: first index scanned by the next pick (one past the last owner),
  // so reset value 0 gives requester 0 top priority.
  logic [OW-1:0]       winner;
  logic [OW-1:0]       win_next;
  logic [OW-1:0]       rr_base;
  logic [OW-1:0]       owner_d;

  logic                latch;
  logic                entering_on;
  logic                owner_req;
  logic                hold_max;
  logic [HW-1:0]       hold;

  logic                timer_load;
  logic [TW-1:0]       timer_val;
  logic                timer_done;

  logic                tmo_next;
  logic                tmo_flag;
  logic [NREQ-1:0]     en_d;

  pgate_dead_timer #(
    .W(TW)
  ) u_dead_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Round-robin candidate and owner-side status used by the FSM.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    pick              = rr_pick(req_ext, IDX_W'(rr_base), NREQ);
    pick_idx          = OW'(pick.index);
    owner_req         = req[winner];
    hold_max          = (hold == HW'(MAX_HOLD));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the control strobes that go with each transition.
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    timer_load = 1'b0;
    timer_val  = TW'(OFF_CYC);
    tmo_next   = 1'b0;
    case (state)
      IDLE: begin
        if (pick.found) begin
          latch = 1'b1;
          if (DEAD_CYC > 0) begin
            next_state = SETTLE;
            timer_load = 1'b1;
            timer_val  = TW'(DEAD_CYC);
          end else begin
            next_state = ON;
          end
        end
      end
      SETTLE: begin
        if (!owner_req) begin
          next_state = IDLE;
        end else if (timer_done) begin
          next_state = ON;
        end
      end
      ON: begin
        if (!owner_req) begin
          next_state = OFF;
          timer_load = 1'b1;
        end else if (hold_max) begin
          next_state = OFF;
          timer_load = 1'b1;
          tmo_next   = 1'b1;
        end
      end
      OFF: begin
        if (timer_done) begin
          if (pick.found) begin
            next_state = ON;
            latch      = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Owner chosen this cycle and whether the bus is being handed to it now.
  always_comb begin
    win_next    = latch ? pick_idx : winner;
    entering_on = (next_state == ON) && (state != ON);
  end

  // Winner latch, round-robin base, hold counter and timeout strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner   <= '0;
      rr_base  <= '0;
      hold     <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= tmo_next;
      if (latch) begin
        winner <= pick_idx;
      end
      if (entering_on) begin
        rr_base <= (win_next == OW'(NREQ - 1)) ? '0 : win_next + 1'b1;
        hold    <= HW'(1);
      end else if ((state == ON) && (next_state == ON)) begin
        hold <= hold + 1'b1;
      end
    end
  end

  // Output decode from the current state; registered on the next edge.
  always_comb begin
    en_d    = '0;
    owner_d = owner;
    if (state == ON) begin
      en_d[winner] = 1'b1;
      owner_d      = winner;
    end
  end

  // Registered gate drives and status; reset turns every gate off at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      en_n    <= '0;
      en_p    <= '1;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      gnt     <= en_d;
      en_n    <= en_d;
      en_p    <= ~en_d;
      owner   <= owner_d;
      busy    <= |en_d;
      timeout <= tmo_flag;
    end
  end

endmodule
